// File: rtl/clock_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles, with a duty-cycle LED bar.
// Results register on the synchronised rising edge; no backpressure, valid is a single-cycle pulse.
module clock_meter #(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] TIMEOUT = 25'd32000000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic [7:0]       leds
);

  localparam int               XW      = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       leds_q, leds_d;

  logic             rise_det;
  logic             fall_det;
  logic [XW-1:0]    hc_x8;
  logic [XW-1:0]    cnt_x;
  logic [7:0]       bar;

  assign rise_det = s2_q & ~s3_q;
  assign fall_det = ~s2_q & s3_q;

  // Thermometer: segment i lights when 8*high > i*period, widened so nothing overflows.
  always_comb begin
    hc_x8 = {3'b000, high_cap_q} << 3;
    cnt_x = {3'b000, cnt_q};
    bar   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bar[i] = hc_x8 > (XW'(i) * cnt_x);
    end
  end

  always_comb begin
    s1_d        = sig_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    high_cap_d  = high_cap_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    leds_d      = leds_q;

    case (state_q)
      IDLE: begin
        // First edge only starts the count; there is no complete period yet.
        cnt_d = '0;
        if (rise_det) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (fall_det) begin
          high_cap_d = cnt_q;
        end
        if (rise_det) begin
          period_d    = cnt_q;
          high_time_d = high_cap_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          leds_d      = bar;
          cnt_d       = CNT_ONE;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          leds_d    = 8'h00;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      high_cap_q  <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      leds_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      high_cap_q  <= high_cap_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      leds_q      <= leds_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_clock_meter.sv
// Directed bench for clock_meter with a shortened timeout of 100 cycles.
module tb_clock_meter;

  localparam int CW = 25;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;
  logic [7:0]    leds;

  int n_chk    = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  int rst_vld  = 0;
  int cyc      = 0;
  int last_vld = 0;
  int vld_gap  = 0;
  int base     = 0;

  clock_meter #(
    .CNT_W  (CW),
    .TIMEOUT(25'd100)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .leds     (leds)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (valid) begin
      vld_cnt  = vld_cnt + 1;
      vld_gap  = cyc - last_vld;
      last_vld = cyc;
      if (!reset) rst_vld = rst_vld + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wave(input int hi, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (per - hi) @(negedge clk_in);
    end
  endtask

  initial begin
    // 1: reset held while sig_in toggles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      sig_in = ~sig_in;
    end
    #1;
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high", 32'(high_time), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_no_vld", 32'(rst_vld), 32'd0);
    @(negedge clk_in);
    sig_in = 1'b0;
    reset  = 1'b1;
    repeat (4) @(negedge clk_in);

    // first rise after reset gives no valid
    base = vld_cnt;
    wave(10, 20, 1);
    #1 chk("first_rise_no_vld", 32'(vld_cnt), 32'(base));
    // 2: 20/10
    wave(10, 20, 4);
    #1;
    chk("p20_vld_cnt", 32'(vld_cnt), 32'(base + 4));
    chk("p20_period", 32'(period), 32'd20);
    chk("p20_high", 32'(high_time), 32'd10);
    chk("p20_leds", 32'(leds), 32'h0F);
    chk("p20_timeout", 32'(timeout), 32'd0);
    chk("p20_gap", 32'(vld_gap), 32'd20);

    // 3: duty 25% and 75%
    wave(5, 20, 3);
    #1;
    chk("d25_high", 32'(high_time), 32'd5);
    chk("d25_leds", 32'(leds), 32'h03);
    wave(15, 20, 3);
    #1;
    chk("d75_high", 32'(high_time), 32'd15);
    chk("d75_leds", 32'(leds), 32'h3F);
    chk("d75_period", 32'(period), 32'd20);

    // 4: signal stops after one rise
    wave(10, 20, 2);
    sig_in = 1'b1;
    repeat (10) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (92) @(negedge clk_in);
    #1 chk("to_not_yet", 32'(timeout), 32'd0);
    @(negedge clk_in);
    #1;
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_leds", 32'(leds), 32'd0);
    chk("to_period", 32'(period), 32'd20);
    chk("to_high", 32'(high_time), 32'd10);
    repeat (5) @(negedge clk_in);
    base = vld_cnt;
    wave(10, 20, 1);
    #1 chk("resume_no_vld", 32'(vld_cnt), 32'(base));
    wave(10, 20, 1);
    #1;
    chk("resume_vld", 32'(vld_cnt), 32'(base + 1));
    chk("resume_timeout", 32'(timeout), 32'd0);
    chk("resume_period", 32'(period), 32'd20);

    // 5: fastest signal
    for (int k = 0; k < 30; k++) begin
      sig_in = ~sig_in;
      @(negedge clk_in);
    end
    #1;
    chk("fast_period", 32'(period), 32'd2);
    chk("fast_high", 32'(high_time), 32'd1);
    chk("fast_leds", 32'(leds), 32'h0F);
    chk("fast_gap", 32'(vld_gap), 32'd2);

    // 6: reset mid-period
    sig_in = 1'b0;
    repeat (5) @(negedge clk_in);
    sig_in = 1'b1;
    repeat (9) @(negedge clk_in);
    reset = 1'b0;
    #1;
    chk("mid_rst_period", 32'(period), 32'd0);
    chk("mid_rst_high", 32'(high_time), 32'd0);
    chk("mid_rst_leds", 32'(leds), 32'd0);
    repeat (2) @(negedge clk_in);
    reset  = 1'b1;
    sig_in = 1'b0;
    repeat (5) @(negedge clk_in);
    base = vld_cnt;
    wave(10, 20, 1);
    #1 chk("mid_rst_no_vld", 32'(vld_cnt), 32'(base));
    wave(10, 20, 1);
    #1;
    chk("mid_rst_vld", 32'(vld_cnt), 32'(base + 1));
    chk("mid_rst_p20", 32'(period), 32'd20);
    chk("mid_rst_h10", 32'(high_time), 32'd10);

    // rise coinciding with cnt == TIMEOUT wins
    wave(50, 100, 3);
    #1;
    chk("edge_period", 32'(period), 32'd100);
    chk("edge_high", 32'(high_time), 32'd50);
    chk("edge_timeout", 32'(timeout), 32'd0);
    chk("edge_leds", 32'(leds), 32'h0F);
    chk("edge_gap", 32'(vld_gap), 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_meter.md
Name: clock_meter

Overview:
- Measures an externally supplied square wave `sig_in`, typically the divided clock from the board's clock divider, looped back or taken from another board.
- Reports period and high time in `clk_in` cycles, plus a timeout flag when the signal stops.
- Shows duty cycle as an 8-LED thermometer bar.
- This is the receiving end of the divider output, used for board bring-up and self-test.

Parameters:
- CNT_W, 25, width of the cycle counter and of the period/high_time outputs.
- TIMEOUT, 25'd32000000, cycles with no rising edge before the measurement is abandoned (1 s at 32 MHz). Must be ≤ 2^CNT_W − 1.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sig_in  input  1  measured signal; asynchronous to clk_in.
- period  output  CNT_W  last measured period, in clk_in cycles.
- high_time  output  CNT_W  last measured high time, in clk_in cycles.
- valid  output  1  one-cycle pulse when period/high_time/leds update.
- timeout  output  1  level; no rising edge seen within TIMEOUT cycles.
- leds  output  8  duty-cycle thermometer.

Behaviour:
- Interface: one clock, clk_in, rising-edge; reset is asynchronous and active-low. All state updates on the rising edge of clk_in.
- Reset (reset=0): state=IDLE; cnt=0; period=0; high_time=0; high_cap=0; valid=0; timeout=0; leds=0; synchroniser and edge registers=0.
- Input path:
  - 2-flop synchroniser s1→s2, then delay register s3.
  - rise_det = s2 & ~s3; fall_det = ~s2 & s3.
  - rise_det asserts 3 clk_in cycles after sig_in rises (constant offset, cancels in measurements).
- State IDLE:
  - cnt holds 0; fall_det is ignored.
  - On rise_det: cnt←1, go to MEASURE, no valid (first edge gives no complete period).
- State MEASURE:
  - Default: cnt←cnt+1.
  - fall_det: high_cap←cnt (cycles from rise_det to fall_det).
  - rise_det:
    - period←cnt; high_time←high_cap; valid←1 next cycle; timeout←0; leds updated; cnt←1.
    - Stay in MEASURE.
  - cnt==TIMEOUT with no rise_det in that cycle: go to IDLE, cnt←0, timeout←1, leds←0; period/high_time hold their values.
  - Simultaneous rise_det and cnt==TIMEOUT: rise_det wins and a normal update occurs.
- Outputs are registered: period/high_time/leds change on the edge where rise_det=1; valid is high for exactly that following cycle.
- leds[i] (i=0..7) = ({3'b0,high_cap}<<3) > (i × {3'b0,cnt}), evaluated at the rise_det cycle at CNT_W+3 bits.
  - leds[0]=1 whenever high_cap>0.
  - Bar length is floor(8·duty) + 1 when the product is not exact, otherwise 8·duty.
- cnt never wraps, since TIMEOUT ≤ 2^CNT_W − 1 forces IDLE first.
- Minimum measurable period is 2 cycles (sig_in toggling every clk_in).
- Glitches shorter than 1 cycle may be missed; no filtering is applied.
- Reset mid-measurement clears everything immediately; the first rise after release produces no valid.

Test Plan (TIMEOUT=100 in sim):
1. Assert reset with sig_in toggling → all outputs 0, valid never pulses while reset=0; after release, the first valid comes on the 2nd synchronised rise, not the 1st.
2. sig_in period 20, high 10 → valid pulses once per 20 cycles from the 2nd rise on; period=20, high_time=10, leds=8'h0F, timeout=0.
3. High 5 / period 20 → high_time=5, leds=8'h03. High 15 / period 20 → high_time=15, leds=8'h3F.
4. Hold sig_in low after a rise → timeout=1 exactly 100 cycles after that rise_det (cnt reaches 100, then registered); leds=0; period/high_time retain 20/10.
   - Resume the 20/10 wave → no valid on the 1st rise; on the 2nd rise valid=1, timeout=0, period=20.
5. Toggle sig_in every clk_in cycle → period=2, high_time=1, leds=8'h0F, valid every 2 cycles.
6. Pulse reset low mid-period (cnt≈7) → outputs 0 immediately (asynchronous); after release, the 2nd rise gives the correct period. Also drive rise_det on the cycle cnt==100 → normal update, no timeout.
